// File: rtl/srl_delay_probe.sv
// srl_delay_probe: flushes a delay line, injects a one-cycle marker and measures cycles until it echoes back.
// Optional feature macro SRL_PROBE_WIDTH_CHECK_EN adds a CHECK state and the owidth_err output.
module srl_delay_probe #(
    parameter int MAX_LAT = 255,
    parameter int LAT_W   = 8
) (
    input  logic             iclk,
    input  logic             irst_n,
    input  logic             istart,
    output logic             oprobe,
    input  logic             iecho,
    output logic             obusy,
    output logic             odone,
    output logic [LAT_W-1:0] olat,
    output logic             otimeout,
`ifdef SRL_PROBE_WIDTH_CHECK_EN
    output logic             owidth_err,
`endif
    output logic             ostuck
);

    localparam int CW = LAT_W + 2;
    localparam logic [CW-1:0] QUIET_END = CW'(MAX_LAT);
    localparam logic [CW-1:0] FLUSH_END = CW'(4 * (MAX_LAT + 1) - 1);
    localparam logic [LAT_W-1:0] LAT_END = LAT_W'(MAX_LAT);

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        FIRE,
        WAIT,
`ifdef SRL_PROBE_WIDTH_CHECK_EN
        CHECK,
`endif
        DONE
    } state_t;

`ifdef SRL_PROBE_WIDTH_CHECK_EN
    localparam state_t ECHO_NEXT = CHECK;
`else
    localparam state_t ECHO_NEXT = DONE;
`endif

    state_t state, state_d;
    logic [CW-1:0] quiet_cnt, flush_cnt;
    logic [LAT_W-1:0] lat_cnt;
    logic counting;

    assign counting = (state == FIRE) || (state == WAIT);
    assign obusy = (state != IDLE) && (state != DONE);
    assign odone = state == DONE;

    // State register; reset abandons any measurement in progress.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) state <= IDLE;
        else state <= state_d;
    end

    // Next state: quiet line wins over the stuck limit, echo wins over timeout.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = istart ? FLUSH : IDLE;
            FLUSH:   state_d = (!iecho && quiet_cnt == QUIET_END) ? FIRE :
                               (flush_cnt == FLUSH_END) ? DONE : FLUSH;
            FIRE:    state_d = iecho ? ECHO_NEXT : WAIT;
            WAIT:    state_d = iecho ? ECHO_NEXT : (lat_cnt == LAT_END) ? DONE : WAIT;
`ifdef SRL_PROBE_WIDTH_CHECK_EN
            CHECK:   state_d = DONE;
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Marker drive is registered so it is high for exactly the FIRE cycle.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) oprobe <= 1'b0;
        else oprobe <= state_d == FIRE;
    end

    // Flush and latency counters; lat_cnt is 0 in FIRE and k in the k-th WAIT cycle.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            quiet_cnt <= '0;
            flush_cnt <= '0;
            lat_cnt   <= '0;
        end else begin
            quiet_cnt <= (state == FLUSH && !iecho) ? quiet_cnt + 1'b1 : '0;
            flush_cnt <= (state == FLUSH) ? flush_cnt + 1'b1 : '0;
            lat_cnt   <= counting ? lat_cnt + 1'b1 : '0;
        end
    end

    // Result registers: cleared on an accepted start, then held until the next one.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            olat     <= '0;
            otimeout <= 1'b0;
            ostuck   <= 1'b0;
        end else if (state == IDLE && istart) begin
            olat     <= '0;
            otimeout <= 1'b0;
            ostuck   <= 1'b0;
        end else begin
            if (counting && iecho) olat <= lat_cnt;
            if (state == WAIT && !iecho && lat_cnt == LAT_END) otimeout <= 1'b1;
            if (state == FLUSH && state_d == DONE) ostuck <= 1'b1;
        end
    end

`ifdef SRL_PROBE_WIDTH_CHECK_EN
    // A marker still present one cycle after its echo means a stretched or stuck output.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) owidth_err <= 1'b0;
        else if (state == IDLE && istart) owidth_err <= 1'b0;
        else if (state == CHECK && iecho) owidth_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_srl_delay_probe.sv
// tb_srl_delay_probe: directed bench for srl_delay_probe (loopback, 128-stage line, timeout, stuck, reset, width).
`timescale 1ns/1ps
module tb_srl_delay_probe;

`ifdef SRL_PROBE_WIDTH_CHECK_EN
    localparam int XD = 1;
`else
    localparam int XD = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    logic probe_a, probe_b, echo_a, echo_b;
    logic busy_a, busy_b, done_a, done_b;
    logic [7:0] lat_a, lat_b;
    logic timeout_a, timeout_b, stuck_a, stuck_b;
`ifdef SRL_PROBE_WIDTH_CHECK_EN
    logic werr_a, werr_b;
`endif
    logic [128:1] line = '0;
    int mode_a = 0;
    logic tie_b = 1'b0;
    int checks = 0;
    int failures = 0;
    int fire_n, done_n;

    srl_delay_probe #(.MAX_LAT(255), .LAT_W(8)) dut_a (
        .iclk(clk), .irst_n(rst_n), .istart(start_a), .oprobe(probe_a), .iecho(echo_a),
        .obusy(busy_a), .odone(done_a), .olat(lat_a), .otimeout(timeout_a),
`ifdef SRL_PROBE_WIDTH_CHECK_EN
        .owidth_err(werr_a),
`endif
        .ostuck(stuck_a)
    );

    srl_delay_probe #(.MAX_LAT(15), .LAT_W(8)) dut_b (
        .iclk(clk), .irst_n(rst_n), .istart(start_b), .oprobe(probe_b), .iecho(echo_b),
        .obusy(busy_b), .odone(done_b), .olat(lat_b), .otimeout(timeout_b),
`ifdef SRL_PROBE_WIDTH_CHECK_EN
        .owidth_err(werr_b),
`endif
        .ostuck(stuck_b)
    );

    always #5 clk = ~clk;

    // 128-stage register delay line driven by dut_a's probe.
    always @(posedge clk) line <= {line[127:1], probe_a};

    // Echo sources: loopback, 128-stage line, or a latency-10 marker stretched to 2 cycles.
    always_comb begin
        echo_a = (mode_a == 0) ? probe_a : (mode_a == 1) ? line[128] : (line[10] | line[11]);
        echo_b = tie_b;
    end

    task automatic run(input bit b, input int extra, output int f_n, output int d_n);
        f_n = 0;
        d_n = 0;
        @(posedge clk); #1;
        if (b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        for (int n = 1; n <= 2000; n++) begin
            @(negedge clk);
            if (n == 1) begin
                checks++;
                if ((b ? busy_b : busy_a) !== 1'b1) begin
                    failures++;
                    $display("FAIL run_busy got=%b exp=1", b ? busy_b : busy_a);
                end
            end
            if (extra != 0 && n == extra) begin
                if (b) start_b = 1'b1; else start_a = 1'b1;
            end
            if (extra != 0 && n == extra + 1) begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            if ((b ? probe_b : probe_a) && f_n == 0) f_n = n;
            if (b ? done_b : done_a) begin
                d_n = n;
                break;
            end
        end
        checks++;
        if (d_n == 0) begin
            failures++;
            $display("FAIL run_no_done got=none exp=odone within 2000 cycles");
        end else begin
            checks++;
            if ((b ? busy_b : busy_a) !== 1'b0) begin
                failures++;
                $display("FAIL done_busy got=%b exp=0", b ? busy_b : busy_a);
            end
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({probe_a, busy_a, done_a, timeout_a, stuck_a} !== 5'b0 || lat_a !== 8'd0) begin
            failures++;
            $display("FAIL reset_a got=%b_%0d exp=00000_0", {probe_a, busy_a, done_a, timeout_a, stuck_a}, lat_a);
        end
        checks++;
        if ({probe_b, busy_b, done_b, timeout_b, stuck_b} !== 5'b0 || lat_b !== 8'd0) begin
            failures++;
            $display("FAIL reset_b got=%b_%0d exp=00000_0", {probe_b, busy_b, done_b, timeout_b, stuck_b}, lat_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_loopback();
        mode_a = 0;
        run(1'b0, 0, fire_n, done_n);
        checks++;
        if (fire_n != 257) begin
            failures++;
            $display("FAIL loop_flush_len got=%0d exp=256", fire_n - 1);
        end
        checks++;
        if (done_n - fire_n != 1 + XD) begin
            failures++;
            $display("FAIL loop_done_delay got=%0d exp=%0d", done_n - fire_n, 1 + XD);
        end
        checks++;
        if (lat_a !== 8'd0 || timeout_a !== 1'b0 || stuck_a !== 1'b0) begin
            failures++;
            $display("FAIL loop_result got=lat%0d_to%b_st%b exp=lat0_to0_st0", lat_a, timeout_a, stuck_a);
        end
`ifdef SRL_PROBE_WIDTH_CHECK_EN
        checks++;
        if (werr_a !== 1'b0) begin
            failures++;
            $display("FAIL loop_werr got=%b exp=0", werr_a);
        end
`endif
    endtask

    task automatic test_line128();
        mode_a = 1;
        run(1'b0, 0, fire_n, done_n);
        checks++;
        if (lat_a !== 8'd128) begin
            failures++;
            $display("FAIL line_lat got=%0d exp=128", lat_a);
        end
        checks++;
        if (done_n - fire_n != 129 + XD) begin
            failures++;
            $display("FAIL line_done_delay got=%0d exp=%0d", done_n - fire_n, 129 + XD);
        end
        checks++;
        if (timeout_a !== 1'b0 || stuck_a !== 1'b0) begin
            failures++;
            $display("FAIL line_flags got=to%b_st%b exp=to0_st0", timeout_a, stuck_a);
        end
    endtask

    task automatic test_back_to_back();
        mode_a = 1;
        run(1'b0, 10, fire_n, done_n);
        checks++;
        if (fire_n != 257) begin
            failures++;
            $display("FAIL b2b_fire got=%0d exp=257", fire_n);
        end
        checks++;
        if (lat_a !== 8'd128) begin
            failures++;
            $display("FAIL b2b_lat got=%0d exp=128", lat_a);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (lat_a !== 8'd128 || done_a !== 1'b0 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL hold got=lat%0d_d%b_b%b exp=lat128_d0_b0", lat_a, done_a, busy_a);
        end
    endtask

    task automatic test_timeout();
        tie_b = 1'b0;
        run(1'b1, 0, fire_n, done_n);
        checks++;
        if (fire_n != 17) begin
            failures++;
            $display("FAIL to_flush_len got=%0d exp=16", fire_n - 1);
        end
        checks++;
        if (done_n - fire_n != 16) begin
            failures++;
            $display("FAIL to_done_delay got=%0d exp=16", done_n - fire_n);
        end
        checks++;
        if (timeout_b !== 1'b1 || lat_b !== 8'd0 || stuck_b !== 1'b0) begin
            failures++;
            $display("FAIL to_result got=to%b_lat%0d_st%b exp=to1_lat0_st0", timeout_b, lat_b, stuck_b);
        end
    endtask

    task automatic test_stuck();
        tie_b = 1'b1;
        run(1'b1, 0, fire_n, done_n);
        checks++;
        if (fire_n != 0) begin
            failures++;
            $display("FAIL stuck_probe got=fired_at_%0d exp=never", fire_n);
        end
        checks++;
        if (done_n != 65) begin
            failures++;
            $display("FAIL stuck_flush_len got=%0d exp=64", done_n - 1);
        end
        checks++;
        if (stuck_b !== 1'b1 || timeout_b !== 1'b0 || lat_b !== 8'd0) begin
            failures++;
            $display("FAIL stuck_result got=st%b_to%b_lat%0d exp=st1_to0_lat0", stuck_b, timeout_b, lat_b);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        mode_a = 1;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (probe_a) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL rst_fire_seen got=none exp=probe high");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (probe_a !== 1'b0 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL rst_fire got=p%b_b%b exp=p0_b0", probe_a, busy_a);
        end
        checks++;
        if (stuck_b !== 1'b0) begin
            failures++;
            $display("FAIL rst_clears_b got=%b exp=0", stuck_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        repeat (300) @(negedge clk);
        checks++;
        if (busy_a !== 1'b1) begin
            failures++;
            $display("FAIL rst_wait_busy got=%b exp=1", busy_a);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({probe_a, busy_a, done_a, timeout_a, stuck_a} !== 5'b0 || lat_a !== 8'd0) begin
            failures++;
            $display("FAIL rst_wait got=%b_%0d exp=00000_0", {probe_a, busy_a, done_a, timeout_a, stuck_a}, lat_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run(1'b0, 0, fire_n, done_n);
        checks++;
        if (lat_a !== 8'd128 || timeout_a !== 1'b0) begin
            failures++;
            $display("FAIL rst_rerun got=lat%0d_to%b exp=lat128_to0", lat_a, timeout_a);
        end
    endtask

    task automatic test_width();
        mode_a = 2;
        run(1'b0, 0, fire_n, done_n);
        checks++;
        if (lat_a !== 8'd10) begin
            failures++;
            $display("FAIL width_lat got=%0d exp=10", lat_a);
        end
        checks++;
        if (done_n - fire_n != 11 + XD) begin
            failures++;
            $display("FAIL width_done_delay got=%0d exp=%0d", done_n - fire_n, 11 + XD);
        end
`ifdef SRL_PROBE_WIDTH_CHECK_EN
        checks++;
        if (werr_a !== 1'b1) begin
            failures++;
            $display("FAIL width_err got=%b exp=1", werr_a);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_line128();
        test_back_to_back();
        test_timeout();
        test_stuck();
        test_reset_mid();
        test_width();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
